// File: rtl/weight_loader_if.sv
// weight_loader_if: control, weight-memory read port and weight stream of the weight loader
interface weight_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13,
  parameter int IDX_W  = 2
);
  logic              load_weight;
  logic [ADDR_W-1:0] base_address;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              weight_valid;
  logic              weight_ready;
  logic [DATA_W-1:0] weight_data;
  logic [IDX_W-1:0]  weight_index;
  logic              busy;
  logic              done;
  modport master (
    input  load_weight, base_address, mem_rd_data, weight_ready,
    output mem_rd_en, mem_addr, weight_valid, weight_data, weight_index, busy, done
  );
  modport slave (
    output load_weight, base_address, mem_rd_data, weight_ready,
    input  mem_rd_en, mem_addr, weight_valid, weight_data, weight_index, busy, done
  );
endinterface

// File: rtl/weight_loader.sv
// weight_loader: streams one tile of weights from memory into the array through a 2-entry buffer
module weight_loader #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 13,
  parameter int N_WEIGHTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic              clk,
  input  logic              reset,
  weight_loader_if.master   bus
);
  localparam int CNT_W = $clog2(N_WEIGHTS + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state_q, state_d;
  logic              lw_q, lw_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [IDX_W-1:0]  accepted_q, accepted_d;
  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic              start, pop, push, last, rd_en;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lw_q       <= 1'b0;
      inflight_q <= 1'b0;
      base_q     <= '0;
      addr_q     <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      count_q    <= '0;
      e0_q       <= '0;
      e1_q       <= '0;
    end else begin
      state_q    <= state_d;
      lw_q       <= lw_d;
      inflight_q <= inflight_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      count_q    <= count_d;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
    end
  end
  always_comb begin
    start      = state_q == IDLE && bus.load_weight && !lw_q;
    push       = state_q == RUN && inflight_q;
    last       = pop && accepted_q == IDX_W'(N_WEIGHTS - 1);
    state_d    = start ? RUN : state_q == RUN ? (last ? DONE : RUN) : state_q == DONE ? IDLE : state_q;
    lw_d       = bus.load_weight;
    inflight_d = rd_en;
    base_d     = start ? bus.base_address : base_q;
    issued_d   = start ? '0 : issued_q + CNT_W'(rd_en);
    accepted_d = start ? '0 : accepted_q + IDX_W'(pop);
    count_d    = count_q + 2'(push) - 2'(pop);
    // the head refills from the second slot, or straight from memory when that slot is empty
    e0_d       = pop ? (count_q == 2'd2 ? e1_q : push ? bus.mem_rd_data : e0_q)
                     : (push && count_q == 2'd0 ? bus.mem_rd_data : e0_q);
    e1_d       = push && ((pop && count_q == 2'd2) || (!pop && count_q == 2'd1)) ? bus.mem_rd_data : e1_q;
  end
  always_comb begin
    pop   = count_q != 2'd0 && bus.weight_ready;
    rd_en = state_q == RUN && issued_q < CNT_W'(N_WEIGHTS)
            && ({1'b0, count_q} + 3'(inflight_q) - 3'(pop)) < 3'd2;
    addr_d           = rd_en ? base_q + ADDR_W'(issued_q) : addr_q;
    bus.mem_rd_en    = rd_en;
    bus.mem_addr     = addr_d;
    bus.weight_valid = count_q != 2'd0;
    bus.weight_data  = e0_q;
    bus.weight_index = accepted_q;
    bus.busy         = state_q == RUN;
    bus.done         = state_q == DONE;
  end
endmodule
